// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-lite encodings for the two-master arbiter slice.
//   HTRANS : IDLE, BUSY, NONSEQ, SEQ
//   HBURST : SINGLE, INCR4, INCR8 (the only bursts the arbiter supports)
//   HSIZE  : BYTE, HALF, WORD
//   owner_t: address/data phase owner encoding (0 = m0, 1 = m1)
package ahb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  // Beats remaining after the first beat of a burst (count loaded on NONSEQ).
  function automatic logic [2:0] burst_last(input logic [2:0] burst);
    case (burst)
      INCR4:   burst_last = 3'd3;
      INCR8:   burst_last = 3'd7;
      default: burst_last = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb2_if.sv
// ahb_arb2_if: bundle of both master ports and the shared slave port.
//   m0_*/m1_* : per-master request, grant and address/data-phase signals
//   s_*       : multiplexed transfer towards the single slave
//   s_readyi  : HREADY from the slave, m_readyi: HREADY fanned to masters
//   hmaster   : current address-phase owner
// Modport slave is the arbiter's view; modport master is the masters'/slave-model view.
interface ahb_arb2_if;
  logic        m0_busreq, m1_busreq;
  logic        m0_grant,  m1_grant;
  logic [31:0] m0_addr,   m1_addr;
  logic        m0_write,  m1_write;
  logic [1:0]  m0_trans,  m1_trans;
  logic [2:0]  m0_size,   m1_size;
  logic [2:0]  m0_burst,  m1_burst;
  logic [31:0] m0_wdata,  m1_wdata;
  logic [31:0] s_addr;
  logic        s_write;
  logic [1:0]  s_trans;
  logic [2:0]  s_size;
  logic [2:0]  s_burst;
  logic [31:0] s_wdata;
  logic        s_readyi;
  logic        m_readyi;
  logic        hmaster;

  modport slave (
    input  m0_busreq, m1_busreq, m0_addr, m1_addr, m0_write, m1_write,
           m0_trans, m1_trans, m0_size, m1_size, m0_burst, m1_burst,
           m0_wdata, m1_wdata, s_readyi,
    output m0_grant, m1_grant, s_addr, s_write, s_trans, s_size, s_burst,
           s_wdata, m_readyi, hmaster
  );

  modport master (
    output m0_busreq, m1_busreq, m0_addr, m1_addr, m0_write, m1_write,
           m0_trans, m1_trans, m0_size, m1_size, m0_burst, m1_burst,
           m0_wdata, m1_wdata, s_readyi,
    input  m0_grant, m1_grant, s_addr, s_write, s_trans, s_size, s_burst,
           s_wdata, m_readyi, hmaster
  );
endinterface

// File: rtl/ahb_beat_cnt.sv
// ahb_beat_cnt: burst beat counter and arbitration-point flag.
//   hclk, rst : clock, synchronous active-high reset
//   ready     : HREADY from the slave; counter only moves on accepted beats
//   trans     : HTRANS of the current address-phase owner
//   burst     : HBURST of the current address-phase owner
//   arb_pt    : this edge may move the grant (combinational)
module ahb_beat_cnt
  import ahb_pkg::*;
#(
  parameter int NUM_BEAT_W = 3
) (
  input  logic       hclk,
  input  logic       rst,
  input  logic       ready,
  input  logic [1:0] trans,
  input  logic [2:0] burst,
  output logic       arb_pt
);

  logic [NUM_BEAT_W-1:0] cnt;
  logic [NUM_BEAT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (ready) begin
      if (trans == NONSEQ) begin
        cnt_nxt = NUM_BEAT_W'(burst_last(burst));
      end else if (trans == SEQ && cnt != '0) begin
        cnt_nxt = cnt - NUM_BEAT_W'(1);
      end
    end
  end

  // A burst's first beat also loads 0 only for SINGLE, but the explicit
  // burst test keeps an INCRx NONSEQ from ever opening a handover window.
  assign arb_pt = ready && (cnt_nxt == '0) && !(trans == NONSEQ && burst != SINGLE);

  always_ff @(posedge hclk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ahb_arb2.sv
// ahb_arb2: two-master AHB-lite arbiter with address/data multiplexing.
//   hclk, rst : clock, synchronous active-high reset
//   bus       : ahb_arb2_if.slave -- master ports m0/m1, slave port s_*,
//               HREADY in/out, registered one-hot grant and hmaster
// Grant is round-robin at arbitration points and parks on the last owner.
// The data-phase owner lags the address-phase owner by one accepted beat so
// write data after a handover still comes from the outgoing master.
module ahb_arb2
  import ahb_pkg::*;
#(
  parameter int NUM_BEAT_W = 3
) (
  input  logic       hclk,
  input  logic       rst,
  ahb_arb2_if.slave  bus
);

  owner_t hmaster_a;
  owner_t hmaster_d;
  owner_t owner_nxt;
  logic   m0_grant_r;
  logic   m1_grant_r;
  logic   arb_pt;

  // Address-phase mux
  always_comb begin
    if (hmaster_a == OWN_M1) begin
      bus.s_addr  = bus.m1_addr;
      bus.s_write = bus.m1_write;
      bus.s_trans = bus.m1_trans;
      bus.s_size  = bus.m1_size;
      bus.s_burst = bus.m1_burst;
    end else begin
      bus.s_addr  = bus.m0_addr;
      bus.s_write = bus.m0_write;
      bus.s_trans = bus.m0_trans;
      bus.s_size  = bus.m0_size;
      bus.s_burst = bus.m0_burst;
    end
  end

  // Data-phase mux
  assign bus.s_wdata  = (hmaster_d == OWN_M1) ? bus.m1_wdata : bus.m0_wdata;
  assign bus.m_readyi = bus.s_readyi;
  assign bus.hmaster  = hmaster_a;
  assign bus.m0_grant = m0_grant_r;
  assign bus.m1_grant = m1_grant_r;

  ahb_beat_cnt #(.NUM_BEAT_W(NUM_BEAT_W)) u_beat_cnt (
    .hclk   (hclk),
    .rst    (rst),
    .ready  (bus.s_readyi),
    .trans  (bus.s_trans),
    .burst  (bus.s_burst),
    .arb_pt (arb_pt)
  );

  // When both request, the master that is not the current owner wins.
  always_comb begin
    owner_nxt = hmaster_a;
    if (bus.m0_busreq && bus.m1_busreq) begin
      owner_nxt = (hmaster_a == OWN_M0) ? OWN_M1 : OWN_M0;
    end else if (bus.m0_busreq) begin
      owner_nxt = OWN_M0;
    end else if (bus.m1_busreq) begin
      owner_nxt = OWN_M1;
    end
  end

  always_ff @(posedge hclk) begin
    if (rst) begin
      hmaster_a  <= OWN_M0;
      hmaster_d  <= OWN_M0;
      m0_grant_r <= 1'b1;
      m1_grant_r <= 1'b0;
    end else if (bus.s_readyi) begin
      hmaster_d <= hmaster_a;
      if (arb_pt) begin
        hmaster_a  <= owner_nxt;
        m0_grant_r <= (owner_nxt == OWN_M0);
        m1_grant_r <= (owner_nxt == OWN_M1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_arb2.sv
module tb_ahb_arb2;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_arb2_if bus ();

  ahb_arb2 #(.NUM_BEAT_W(3)) dut (
    .hclk (clk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner of address phase, owner of data phase, and how
  // many beats of the current burst are still to come.
  int mown   = 0;
  int mown_d = 0;
  int mleft  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      INCR4:   return 4;
      INCR8:   return 8;
      default: return 1;
    endcase
  endfunction

  task automatic model_edge();
    logic [1:0] tr;
    logic [2:0] bu;
    int prev;
    if (rst) begin
      mown = 0; mown_d = 0; mleft = 0;
    end else if (bus.s_readyi) begin
      tr   = (mown == 1) ? bus.m1_trans : bus.m0_trans;
      bu   = (mown == 1) ? bus.m1_burst : bus.m0_burst;
      prev = mown;
      if (tr == NONSEQ) mleft = burst_beats(bu) - 1;
      else if (tr == SEQ && mleft > 0) mleft = mleft - 1;
      if (mleft == 0 && !(tr == NONSEQ && bu != SINGLE)) begin
        if (bus.m0_busreq && bus.m1_busreq) mown = 1 - mown;
        else if (bus.m0_busreq) mown = 0;
        else if (bus.m1_busreq) mown = 1;
      end
      mown_d = prev;
    end
  endtask

  task automatic check_model();
    check("m0_grant", 32'(bus.m0_grant), 32'(mown == 0));
    check("m1_grant", 32'(bus.m1_grant), 32'(mown == 1));
    check("hmaster",  32'(bus.hmaster),  32'(mown));
    check("s_addr",   bus.s_addr,  (mown == 1) ? bus.m1_addr : bus.m0_addr);
    check("s_write",  32'(bus.s_write), 32'((mown == 1) ? bus.m1_write : bus.m0_write));
    check("s_trans",  32'(bus.s_trans), 32'((mown == 1) ? bus.m1_trans : bus.m0_trans));
    check("s_size",   32'(bus.s_size),  32'((mown == 1) ? bus.m1_size  : bus.m0_size));
    check("s_burst",  32'(bus.s_burst), 32'((mown == 1) ? bus.m1_burst : bus.m0_burst));
    check("s_wdata",  bus.s_wdata, (mown_d == 1) ? bus.m1_wdata : bus.m0_wdata);
    check("m_readyi", 32'(bus.m_readyi), 32'(bus.s_readyi));
  endtask

  // One bus cycle: compare against the model mid-cycle, then advance both.
  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_all();
    bus.m0_busreq = 1'b0; bus.m1_busreq = 1'b0;
    bus.m0_addr   = '0;   bus.m1_addr   = '0;
    bus.m0_write  = 1'b0; bus.m1_write  = 1'b0;
    bus.m0_trans  = IDLE; bus.m1_trans  = IDLE;
    bus.m0_size   = WORD; bus.m1_size   = WORD;
    bus.m0_burst  = SINGLE; bus.m1_burst = SINGLE;
    bus.m0_wdata  = '0;   bus.m1_wdata  = '0;
    bus.s_readyi  = 1'b1;
  endtask

  function automatic logic [1:0] rand_trans();
    case ($urandom_range(0, 2))
      0:       return IDLE;
      1:       return NONSEQ;
      default: return SEQ;
    endcase
  endfunction

  function automatic logic [2:0] rand_burst();
    case ($urandom_range(0, 2))
      0:       return SINGLE;
      1:       return INCR4;
      default: return INCR8;
    endcase
  endfunction

  initial begin
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Reset park
    bus.m0_trans = SEQ;
    bus.m1_trans = NONSEQ;
    step();
    #1;
    check("reset_m0_grant", 32'(bus.m0_grant), 32'd1);
    check("reset_m1_grant", 32'(bus.m1_grant), 32'd0);
    check("reset_hmaster",  32'(bus.hmaster),  32'd0);
    check("reset_s_trans",  32'(bus.s_trans),  32'(SEQ));
    rst = 1'b0;
    idle_all();

    // Single handover to m1
    bus.m1_busreq = 1'b1;
    step();
    check("ho_m1_grant", 32'(bus.m1_grant), 32'd1);
    check("ho_hmaster",  32'(bus.hmaster),  32'd1);
    bus.m1_trans = NONSEQ; bus.m1_burst = SINGLE; bus.m1_write = 1'b1;
    bus.m1_addr  = 32'h10;
    #1;
    check("ho_s_addr", bus.s_addr, 32'h10);
    step();
    bus.m1_trans = IDLE; bus.m1_wdata = 32'hA5A5A5A5;
    #1;
    check("ho_s_wdata", bus.s_wdata, 32'hA5A5A5A5);
    step();
    bus.m1_busreq = 1'b0;
    step();
    check("park_m1", 32'(bus.hmaster), 32'd1);

    // Burst atomicity: m0 INCR4 while m1 keeps requesting
    bus.m0_busreq = 1'b1;
    step();
    check("burst_take_m0", 32'(bus.hmaster), 32'd0);
    bus.m1_busreq = 1'b1;
    bus.m0_trans = NONSEQ; bus.m0_burst = INCR4; bus.m0_addr = 32'h20;
    step();
    check("burst_beat1_m0_grant", 32'(bus.m0_grant), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      bus.m0_trans = SEQ;
      bus.m0_addr  = 32'h20 + 32'(4 * i);
      step();
      check("burst_m1_grant", 32'(bus.m1_grant), 32'(i == 3));
    end

    // Round-robin with back-to-back SINGLEs from both masters
    bus.m0_trans = NONSEQ; bus.m0_burst = SINGLE;
    bus.m1_trans = NONSEQ; bus.m1_burst = SINGLE;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_hmaster", 32'(bus.hmaster), 32'(i % 2));
    end

    // Wait states during m0's write data phase across a handover
    bus.m0_busreq = 1'b1; bus.m1_busreq = 1'b0;
    bus.m1_trans = IDLE;
    bus.m0_trans = NONSEQ; bus.m0_write = 1'b1; bus.m0_addr = 32'h40;
    step();
    check("ws_take_m0", 32'(bus.hmaster), 32'd0);
    bus.m0_busreq = 1'b0; bus.m1_busreq = 1'b1;
    step();
    check("ws_hmaster_m1", 32'(bus.hmaster), 32'd1);
    bus.m0_trans = IDLE; bus.m0_wdata = 32'h12345678;
    bus.m1_trans = NONSEQ; bus.m1_write = 1'b1; bus.m1_addr = 32'h50;
    bus.m1_wdata = 32'h0;
    bus.s_readyi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_hold_wdata", bus.s_wdata, 32'h12345678);
      check("ws_hold_hmaster", 32'(bus.hmaster), 32'd1);
      step();
    end
    bus.s_readyi = 1'b1;
    #1;
    check("ws_release_wdata", bus.s_wdata, 32'h12345678);
    step();
    bus.m1_trans = IDLE; bus.m1_wdata = 32'hDEADBEEF;
    #1;
    check("ws_new_data_owner", bus.s_wdata, 32'hDEADBEEF);
    step();

    // Reset in the middle of an m1 INCR8
    bus.m1_trans = NONSEQ; bus.m1_burst = INCR8; bus.m1_addr = 32'h100;
    step();
    bus.m1_trans = SEQ; bus.m1_addr = 32'h104;
    step();
    bus.m1_addr = 32'h108;
    step();
    bus.m1_addr = 32'h10C;
    rst = 1'b1;
    step();
    check("rst8_m0_grant", 32'(bus.m0_grant), 32'd1);
    check("rst8_hmaster",  32'(bus.hmaster),  32'd0);
    rst = 1'b0;
    bus.m0_trans = IDLE; bus.m0_busreq = 1'b0; bus.m1_busreq = 1'b1;
    step();
    check("rst8_regrant_m1", 32'(bus.m1_grant), 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 40) == 0);
      bus.m0_busreq = 1'($urandom_range(0, 1));
      bus.m1_busreq = 1'($urandom_range(0, 1));
      bus.m0_trans  = rand_trans();
      bus.m1_trans  = rand_trans();
      bus.m0_burst  = rand_burst();
      bus.m1_burst  = rand_burst();
      bus.m0_addr   = $urandom;
      bus.m1_addr   = $urandom;
      bus.m0_write  = 1'($urandom_range(0, 1));
      bus.m1_write  = 1'($urandom_range(0, 1));
      bus.m0_size   = 3'($urandom_range(0, 2));
      bus.m1_size   = 3'($urandom_range(0, 2));
      bus.m0_wdata  = $urandom;
      bus.m1_wdata  = $urandom;
      bus.s_readyi  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arb2.md
# ahb_arb2

Two-master AHB-lite arbiter and address/data multiplexer that shares the single ahb2sram slave port between two masters. It holds a registered grant with round-robin priority and parks on the last owner when no master requests. It keeps INCR4/INCR8 bursts atomic, and tracks address-phase and data-phase ownership separately so that write data is steered correctly across a handover.

## Interface
- NUM_BEAT_W, 3, width of the burst beat counter (supports up to INCR8)
- hclk  in  1  bus clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- m0_busreq, m1_busreq  in  1  bus request per master
- m0_grant, m1_grant  out  1  registered grant, one-hot
- m0_addr, m1_addr  in  32  master address
- m0_write, m1_write  in  1  master write flag
- m0_trans, m1_trans  in  2  master HTRANS
- m0_size, m1_size  in  3  master HSIZE
- m0_burst, m1_burst  in  3  master HBURST (SINGLE, INCR4 and INCR8 only)
- m0_wdata, m1_wdata  in  32  master write data
- s_addr  out  32  address to slave
- s_write  out  1  write flag to slave
- s_trans  out  2  HTRANS to slave
- s_size  out  3  HSIZE to slave
- s_burst  out  3  HBURST to slave
- s_wdata  out  32  write data to slave
- s_readyi  in  1  HREADY from slave
- m_readyi  out  1  HREADY fanned to both masters, equal to s_readyi
- hmaster  out  1  current address-phase owner (0 = m0, 1 = m1)

## Operation
- **Address mux.**
  - s_addr, s_write, s_trans, s_size and s_burst come from the master selected by hmaster.
  - The non-owner's trans is ignored.
- **Data mux.** s_wdata comes from the master selected by hmaster_d, the data-phase owner. hmaster_d loads hmaster on each edge with s_readyi = 1.
- **Beat counter.** Only advances on edges where s_readyi = 1.
  - s_trans = NONSEQ with INCR4 loads 3; with INCR8 loads 7; with SINGLE loads 0.
  - s_trans = SEQ with count > 0 decrements the count.
- **Arbitration point.** An edge where all three hold:
  - s_readyi = 1;
  - the counter value after this edge's update is 0;
  - s_trans is not NONSEQ with burst ≠ SINGLE.
- **Grant update at an arbitration point.**
  - If exactly one master requests, it is granted.
  - If both request, the master that is not the current hmaster is granted (round-robin).
  - If neither requests, the grant stays with the current owner (park).
  - Grant and hmaster update on the same edge.
- **Outside arbitration points,** grant and hmaster hold.
- **Illegal input:** a SEQ seen with count = 0 is passed through and the counter holds at 0.

## Timing
- **Reset values:**
  - m0_grant = 1, m1_grant = 0;
  - hmaster = 0, hmaster_d = 0;
  - beat count = 0;
  - the s_* outputs follow the m0 inputs.
- **Latency:**
  - Request to grant is 1 cycle if the bus is at an arbitration point.
  - The new owner's address phase starts on the cycle after the grant edge.
- **Handover:** on the edge where hmaster changes, hmaster_d still holds the previous owner, so the outgoing write data phase completes with the old master's wdata.
- **Wait states:** while s_readyi = 0, grant, hmaster, hmaster_d and the counter all hold.
- **Simultaneous events:** a request deassert and a new request on the same edge are evaluated with current input values only; there is no request memory.
- **Reset mid-burst:** reset on any edge returns all state to reset values on that edge, regardless of counter value.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS constants IDLE, NONSEQ, SEQ;
  - HBURST constants SINGLE, INCR4, INCR8;
  - HSIZE constants BYTE, HALF, WORD.
- One natural sub-module, ahb_beat_cnt: the beat counter plus the arbitration-point flag output. The muxes and the grant FSM stay in the top level.

## Test plan
- **Reset park:** assert rst 2 cycles, no requests → m0_grant = 1, hmaster = 0, s_trans follows m0_trans.
- **Single handover:**
  - Stimulus: m1_busreq = 1 with m0 idle; then m1 writes SINGLE, addr 0x10, wdata 0xA5A5A5A5.
  - Required: m1_grant = 1 one cycle later; s_addr = 0x10 in the address phase; s_wdata = 0xA5A5A5A5 in the data phase.
- **Burst atomicity:**
  - Stimulus: m0 issues INCR4 from 0x20 while m1_busreq = 1 throughout.
  - Required: the grant does not move until after the 4th beat (0x2C) is accepted, then m1_grant = 1.
- **Round-robin:** both request continuously, each doing SINGLE transfers → grants alternate m0, m1, m0, m1.
- **Wait state at handover:**
  - Stimulus: s_readyi = 0 for 3 cycles during m0's write data phase (0x12345678) while the grant moves to m1.
  - Required: s_wdata stays 0x12345678 until s_readyi = 1; hmaster_d then switches to 1.
- **Reset mid-INCR8:** assert rst after beat 3 → the next cycle shows m0_grant = 1, counter 0, and m1 can be granted at the following arbitration point.
